// File: rtl/trace_nop_decoder.sv
// Per-core trace monitor: decodes l.nop K-codes into console chars, reports and exit.
// Optional idle watchdog enabled by defining TRACE_NOP_DECODER_TIMEOUT_EN.
module trace_nop_decoder #(
    parameter int ID              = 0,
    parameter int NUM_TERM        = 4,
    parameter int CHAR_FIFO_DEPTH = 8,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trace_valid,
    input  logic [31:0]         trace_pc,
    input  logic [31:0]         trace_insn,
    input  logic                trace_wben,
    input  logic [4:0]          trace_wbreg,
    input  logic [31:0]         trace_wbdata,
    output logic                char_valid,
    output logic [7:0]          char_data,
    input  logic                char_ready,
    output logic                report_valid,
    output logic [31:0]         report_data,
    output logic                term_o,
    output logic [31:0]         exit_code,
    output logic                all_term_o,
    input  logic [NUM_TERM-1:0] term_all_i,
    output logic                overflow_o,
    output logic [15:0]         id_o,
    output logic                timeout_o
);
    localparam int AW = $clog2(CHAR_FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   r3_q;
    logic [7:0]    mem_q [CHAR_FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, rep_vld_q, term_q, all_term_q;
    logic [31:0]   rep_data_q, exit_q;

    logic          nop, do_exit, do_putc, do_rep, pop, full, push, drop, to_fire;
    logic [15:0]   k;

    logic unused_bits;
    assign unused_bits = ^{trace_pc, trace_insn[23:16]};

    always_comb begin
        nop     = trace_valid && (trace_insn[31:24] == 8'h15) && (state_q == ST_RUN);
        k       = trace_insn[15:0];
        do_exit = nop && (k == 16'h0001);
        do_rep  = nop && (k == 16'h0002);
        do_putc = nop && (k == 16'h0004);
        pop     = (cnt_q != '0) && char_ready;
        full    = (cnt_q == CW'(CHAR_FIFO_DEPTH));
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        push    = do_putc && (!full || pop);
        drop    = do_putc && full && !pop;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (do_exit || to_fire) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0) state_d = ST_DONE;
            default:  state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            r3_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rep_vld_q  <= 1'b0;
            rep_data_q <= '0;
            term_q     <= 1'b0;
            exit_q     <= '0;
            all_term_q <= 1'b0;
            for (int i = 0; i < CHAR_FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (trace_valid && trace_wben && trace_wbreg == 5'd3) r3_q <= trace_wbdata;
            if (push) begin
                mem_q[wr_q] <= r3_q[7:0];
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (drop) ovf_q <= 1'b1;
            rep_vld_q <= do_rep;
            if (do_rep) rep_data_q <= r3_q;
            if (do_exit) begin
                term_q <= 1'b1;
                exit_q <= r3_q;
            end else if (to_fire) begin
                term_q <= 1'b1;
                exit_q <= 32'hDEAD_0000;
            end
            all_term_q <= all_term_q | ((state_q == ST_DONE) && (&term_all_i));
        end
    end

`ifdef TRACE_NOP_DECODER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q;
    logic          timeout_q;

    always_comb to_fire = (state_q == ST_RUN) && !trace_valid &&
                          (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (trace_valid) idle_q <= '0;
            else if (idle_q != TW'(TIMEOUT_CYCLES)) idle_q <= idle_q + 1'b1;
            if (to_fire) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign char_valid   = (cnt_q != '0);
    assign char_data    = mem_q[rd_q];
    assign report_valid = rep_vld_q;
    assign report_data  = rep_data_q;
    assign term_o       = term_q;
    assign exit_code    = exit_q;
    assign all_term_o   = all_term_q;
    assign overflow_o   = ovf_q;
    assign id_o         = 16'(ID);
endmodule
